lii_out_packer: RTL and testbench

- Transmit-side counterpart of the kernel output unpack wrapper.
- Accepts the HLS kernel's narrow AXI-Stream result words and packs K = PW/DW words per beat into one LII physical output channel (p0).
- Stamps each LII beat with fixed src/dst IDs.
- Holds back-pressure and drives the kernel clock enable.

---
 rtl/lii_pkg.sv | 30 +++
 rtl/lii_beat_reg.sv | 70 +++++++
 rtl/lii_out_packer.sv | 181 ++++++++++++++++++
 tb/tb_lii_out_packer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lii_pkg.sv
// ---------------------------------------------------------------------------
// lii_pkg
// Shared definitions for the LII packing blocks: ID width, default packing
// width, the packer FSM state type and a lane-counter width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package lii_pkg;

    // Width of the src/dst identifiers stamped on every LII beat.
    localparam int LII_ID_W = 8;

    // Default LII physical channel width.
    localparam int LII_DEFAULT_PW = 256;

    // Packer FSM: FILL collects words, HOLD parks a finished beat in the
    // accumulator while the output register is still occupied.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_e;

    // Width of a counter indexing n lanes.
    // Never returns less than 1, so the counter stays legal when n == 1.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lii_beat_reg.sv
// ---------------------------------------------------------------------------
// lii_beat_reg
// Output register stage of the LII packer: holds one beat with a valid/ready
// handshake. A load that coincides with a handshake replaces the old beat,
// and valid stays high.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   load_i      in   load a new beat this cycle
//   data_i      in   PW  beat data to load
//   keep_i      in   K   lane mask to load
//   last_i      in   packet-end flag to load
//   ready_i     in   downstream accepts the held beat
//   valid_o     out  a beat is held
//   data_o      out  PW  held beat data
//   keep_o      out  K   held lane mask
//   last_o      out  held packet-end flag
//   slot_free_o out  register may take a new beat this cycle
// ---------------------------------------------------------------------------
module lii_beat_reg #(
    parameter int PW = 256,
    parameter int K  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [PW-1:0] data_i,
    input  logic [K-1:0]  keep_i,
    input  logic          last_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [PW-1:0] data_o,
    output logic [K-1:0]  keep_o,
    output logic          last_o,
    output logic          slot_free_o
);

    logic          valid_q;
    logic [PW-1:0] data_q;
    logic [K-1:0]  keep_q;
    logic          last_q;

    // The slot is free if it is empty or its beat leaves this cycle.
    assign slot_free_o = !valid_q || ready_i;

    // A load always wins over a plain handshake, which is what gives
    // bubble-free replacement. Otherwise a handshake only drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/lii_out_packer.sv
// ---------------------------------------------------------------------------
// lii_out_packer
// Packs K = PW/DW narrow kernel result words into one LII beat on channel p0.
// A beat goes out when all K lanes are filled or the kernel marks tlast.
// Each beat is stamped with constant src/dst IDs. Kernel stalls are exposed
// through ce, which equals in_stream_tready.
// K must be a power of two, and PW must be a multiple of DW.
//
// Ports:
//   aclk               in   clock
//   arst               in   asynchronous active-high reset
//   in_stream_tdata    in   DW  kernel result word
//   in_stream_tvalid   in   kernel word valid
//   in_stream_tready   out  packer accepts word
//   in_stream_tlast    in   last word of packet, flushes a partial beat
//   lii_out_p0_tdata   out  PW  packed beat (lane 0 = bits DW-1:0)
//   lii_out_p0_tvalid  out  beat valid
//   lii_out_p0_tready  in   phy accepts beat
//   lii_out_p0_tkeep   out  K   lane-valid mask
//   lii_out_p0_tlast   out  beat closes a packet
//   lii_out_p0_src     out  8   constant SRC_ID
//   lii_out_p0_dst     out  8   constant DST_ID
//   ce                 out  kernel clock enable
// ---------------------------------------------------------------------------
module lii_out_packer
    import lii_pkg::*;
#(
    parameter int                    DW     = 64,
    parameter int                    PW     = LII_DEFAULT_PW,
    parameter logic [LII_ID_W-1:0]   SRC_ID = 8'h00,
    parameter logic [LII_ID_W-1:0]   DST_ID = 8'h01,
    localparam int                   K      = PW / DW
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [DW-1:0]       in_stream_tdata,
    input  logic                in_stream_tvalid,
    output logic                in_stream_tready,
    input  logic                in_stream_tlast,
    output logic [PW-1:0]       lii_out_p0_tdata,
    output logic                lii_out_p0_tvalid,
    input  logic                lii_out_p0_tready,
    output logic [K-1:0]        lii_out_p0_tkeep,
    output logic                lii_out_p0_tlast,
    output logic [LII_ID_W-1:0] lii_out_p0_src,
    output logic [LII_ID_W-1:0] lii_out_p0_dst,
    output logic                ce
);

    localparam int CW = clog2_min1(K);

    packer_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] acc_data_q, acc_data_d;
    logic [K-1:0]  acc_keep_q, acc_keep_d;
    logic          acc_last_q, acc_last_d;

    logic          slot_free;
    logic          accept;
    logic          complete;
    logic          load;
    logic [PW-1:0] merged_data;
    logic [K-1:0]  merged_keep;
    logic [PW-1:0] load_data;
    logic [K-1:0]  load_keep;
    logic          load_last;

    assign lii_out_p0_src = SRC_ID;
    assign lii_out_p0_dst = DST_ID;

    // Ready is gated by arst so the kernel sees a stall while reset is held.
    assign in_stream_tready = (state_q == FILL) && !arst;
    assign ce               = in_stream_tready;
    assign accept           = in_stream_tready && in_stream_tvalid;
    assign complete         = accept && ((cnt_q == CW'(K - 1)) || in_stream_tlast);

    // Accumulator contents with the incoming word dropped into lane cnt.
    // This is what a completing word turns into, with no extra cycle.
    always_comb begin
        merged_data = acc_data_q;
        merged_keep = acc_keep_q;
        for (int l = 0; l < K; l++) begin
            if (cnt_q == CW'(l)) begin
                merged_data[l*DW +: DW] = in_stream_tdata;
                merged_keep[l]          = 1'b1;
            end
        end
    end

    // Next-state and load control.
    // In FILL, a completing word goes straight to the output register when
    // the slot is free; otherwise it is parked in the accumulator and input
    // stalls in HOLD. In HOLD, the parked beat moves out once the slot frees.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        acc_last_d = acc_last_q;
        load       = 1'b0;
        load_data  = merged_data;
        load_keep  = merged_keep;
        load_last  = in_stream_tlast;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (complete) begin
                        cnt_d = '0;
                        if (slot_free) begin
                            load       = 1'b1;
                            acc_data_d = '0;
                            acc_keep_d = '0;
                            acc_last_d = 1'b0;
                        end else begin
                            acc_data_d = merged_data;
                            acc_keep_d = merged_keep;
                            acc_last_d = in_stream_tlast;
                            state_d    = HOLD;
                        end
                    end else begin
                        acc_data_d = merged_data;
                        acc_keep_d = merged_keep;
                        cnt_d      = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                load_data = acc_data_q;
                load_keep = acc_keep_q;
                load_last = acc_last_q;
                if (slot_free) begin
                    load       = 1'b1;
                    acc_data_d = '0;
                    acc_keep_d = '0;
                    acc_last_d = 1'b0;
                    state_d    = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and accumulator registers. Reset drops any partial beat.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            acc_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            acc_last_q <= acc_last_d;
        end
    end

    lii_beat_reg #(
        .PW (PW),
        .K  (K)
    ) u_beat_reg (
        .clk         (aclk),
        .rst         (arst),
        .load_i      (load),
        .data_i      (load_data),
        .keep_i      (load_keep),
        .last_i      (load_last),
        .ready_i     (lii_out_p0_tready),
        .valid_o     (lii_out_p0_tvalid),
        .data_o      (lii_out_p0_tdata),
        .keep_o      (lii_out_p0_tkeep),
        .last_o      (lii_out_p0_tlast),
        .slot_free_o (slot_free)
    );

endmodule

// File: tb/tb_lii_out_packer.sv
// ---------------------------------------------------------------------------
// tb_lii_out_packer
// Directed bench for lii_out_packer. It uses a K=4 instance (DW=64, PW=256)
// and a K=1 instance (DW=PW=256). Expected beats are queued as words are
// driven, then popped and compared whenever a beat handshakes on the output.
// ---------------------------------------------------------------------------
module tb_lii_out_packer;

    typedef struct {
        logic [255:0] data;
        logic [3:0]   keep;
        logic         last;
    } beat_t;

    logic clk;
    logic rst;

    // K=4 instance signals
    logic [63:0]  inData;
    logic         inVal;
    logic         inLast;
    logic         inReady;
    logic [255:0] outData;
    logic         outValid;
    logic         outReady;
    logic [3:0]   outKeep;
    logic         outLast;
    logic [7:0]   src;
    logic [7:0]   dst;
    logic         ce;

    // K=1 instance signals
    logic [255:0] k1Data;
    logic         k1Val;
    logic         k1Last;
    logic         k1InReady;
    logic [255:0] k1OutData;
    logic         k1OutValid;
    logic         k1OutReady;
    logic [0:0]   k1OutKeep;
    logic         k1OutLast;
    logic [7:0]   k1Src;
    logic [7:0]   k1Dst;
    logic         k1Ce;

    beat_t expQ[$];
    beat_t k1Q[$];

    int testsRun    = 0;
    int testsFailed = 0;

    lii_out_packer #(
        .DW (64),
        .PW (256)
    ) dut (
        .aclk              (clk),
        .arst              (rst),
        .in_stream_tdata   (inData),
        .in_stream_tvalid  (inVal),
        .in_stream_tready  (inReady),
        .in_stream_tlast   (inLast),
        .lii_out_p0_tdata  (outData),
        .lii_out_p0_tvalid (outValid),
        .lii_out_p0_tready (outReady),
        .lii_out_p0_tkeep  (outKeep),
        .lii_out_p0_tlast  (outLast),
        .lii_out_p0_src    (src),
        .lii_out_p0_dst    (dst),
        .ce                (ce)
    );

    lii_out_packer #(
        .DW (256),
        .PW (256)
    ) dutK1 (
        .aclk              (clk),
        .arst              (rst),
        .in_stream_tdata   (k1Data),
        .in_stream_tvalid  (k1Val),
        .in_stream_tready  (k1InReady),
        .in_stream_tlast   (k1Last),
        .lii_out_p0_tdata  (k1OutData),
        .lii_out_p0_tvalid (k1OutValid),
        .lii_out_p0_tready (k1OutReady),
        .lii_out_p0_tkeep  (k1OutKeep),
        .lii_out_p0_tlast  (k1OutLast),
        .lii_out_p0_src    (k1Src),
        .lii_out_p0_dst    (k1Dst),
        .ce                (k1Ce)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue one expected K=4 beat, giving lanes 3..0.
    task automatic pushBeat(input logic [63:0] w3, input logic [63:0] w2,
                            input logic [63:0] w1, input logic [63:0] w0,
                            input logic [3:0] keep, input logic last);
        beat_t b;
        b.data = {w3, w2, w1, w0};
        b.keep = keep;
        b.last = last;
        expQ.push_back(b);
    endtask

    // Present one word and keep it valid until the packer takes it.
    // Returns one step after the accepting edge, with the word still driven.
    task automatic applyStimulus(input logic [63:0] d, input logic last);
        bit done;
        done   = 1'b0;
        inVal  = 1'b1;
        inData = d;
        inLast = last;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (inReady) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            testsRun++;
            testsFailed++;
            $error("[TB] FAIL accept_timeout: word %0h observed not accepted expected accepted", d);
        end
    endtask

    task automatic idle();
        inVal  = 1'b0;
        inLast = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each output handshake pops one expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $error("[TB] FAIL beatA_unexpected: observed %0h expected no beat", outData);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("beatA_data", outData, e.data);
                    checkOutput("beatA_keep", 256'(outKeep), 256'(e.keep));
                    checkOutput("beatA_last", 256'(outLast), 256'(e.last));
                end
            end
            if (k1OutValid && k1OutReady) begin
                if (k1Q.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $error("[TB] FAIL beatK1_unexpected: observed %0h expected no beat", k1OutData);
                end else begin
                    beat_t e;
                    e = k1Q.pop_front();
                    checkOutput("beatK1_data", k1OutData, e.data);
                    checkOutput("beatK1_keep", 256'(k1OutKeep), 256'(e.keep));
                    checkOutput("beatK1_last", 256'(k1OutLast), 256'(e.last));
                end
            end
        end
    end

    // Directed sequence
    initial begin
        rst        = 1'b1;
        inData     = '0;
        inVal      = 1'b0;
        inLast     = 1'b0;
        outReady   = 1'b0;
        k1Data     = '0;
        k1Val      = 1'b0;
        k1Last     = 1'b0;
        k1OutReady = 1'b1;

        // Reset state
        waitCycles(3);
        checkOutput("rst_tvalid", 256'(outValid), 256'(0));
        checkOutput("rst_tready", 256'(inReady), 256'(0));
        checkOutput("rst_ce", 256'(ce), 256'(0));
        checkOutput("rst_src", 256'(src), 256'(8'h00));
        checkOutput("rst_dst", 256'(dst), 256'(8'h01));
        checkOutput("rst_k1_tready", 256'(k1InReady), 256'(0));
        checkOutput("rst_k1_src_dst", 256'({k1Src, k1Dst}), 256'(16'h0001));
        rst = 1'b0;

        // Streaming with the phy always ready: two full beats, one cycle latency
        outReady = 1'b1;
        pushBeat(64'h4, 64'h3, 64'h2, 64'h1, 4'hF, 1'b0);
        pushBeat(64'h8, 64'h7, 64'h6, 64'h5, 4'hF, 1'b1);
        applyStimulus(64'h1, 1'b0);
        applyStimulus(64'h2, 1'b0);
        applyStimulus(64'h3, 1'b0);
        checkOutput("lat_before_complete", 256'(outValid), 256'(0));
        applyStimulus(64'h4, 1'b0);
        checkOutput("lat_after_complete", 256'(outValid), 256'(1));
        applyStimulus(64'h5, 1'b0);
        applyStimulus(64'h6, 1'b0);
        applyStimulus(64'h7, 1'b0);
        applyStimulus(64'h8, 1'b1);
        idle();
        waitCycles(3);

        // Partial flush on tlast
        pushBeat(64'h0, 64'h0, 64'hB, 64'hA, 4'b0011, 1'b1);
        applyStimulus(64'hA, 1'b0);
        applyStimulus(64'hB, 1'b1);
        idle();
        waitCycles(3);

        // Back-pressure: only 8 of 12 words fit while the phy is stalled
        outReady = 1'b0;
        pushBeat(64'h104, 64'h103, 64'h102, 64'h101, 4'hF, 1'b0);
        pushBeat(64'h108, 64'h107, 64'h106, 64'h105, 4'hF, 1'b0);
        pushBeat(64'h10C, 64'h10B, 64'h10A, 64'h109, 4'hF, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(64'h100 + 64'(i), 1'b0);
        end
        inVal  = 1'b1;
        inData = 64'h109;
        inLast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_tready", 256'(inReady), 256'(0));
            checkOutput("bp_ce", 256'(ce), 256'(0));
        end
        checkOutput("bp_tvalid_held", 256'(outValid), 256'(1));
        @(posedge clk);
        #1;
        outReady = 1'b1;
        for (int i = 9; i <= 12; i++) begin
            applyStimulus(64'h100 + 64'(i), (i == 12) ? 1'b1 : 1'b0);
        end
        idle();
        waitCycles(6);

        // A completing word arrives while the previous beat is handshaking
        pushBeat(64'h0, 64'h0, 64'h0, 64'h41, 4'b0001, 1'b1);
        pushBeat(64'h0, 64'h0, 64'h0, 64'h42, 4'b0001, 1'b1);
        applyStimulus(64'h41, 1'b1);
        checkOutput("sim_valid_first", 256'(outValid), 256'(1));
        applyStimulus(64'h42, 1'b1);
        checkOutput("sim_valid_replace", 256'(outValid), 256'(1));
        checkOutput("sim_data_replace", 256'(outData[63:0]), 256'(64'h42));
        idle();
        waitCycles(3);

        // Reset in the middle of a beat drops the partial words
        applyStimulus(64'h21, 1'b0);
        applyStimulus(64'h22, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        checkOutput("midrst_tvalid", 256'(outValid), 256'(0));
        checkOutput("midrst_tready", 256'(inReady), 256'(0));
        checkOutput("midrst_ce", 256'(ce), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushBeat(64'h34, 64'h33, 64'h32, 64'h31, 4'hF, 1'b0);
        applyStimulus(64'h31, 1'b0);
        applyStimulus(64'h32, 1'b0);
        applyStimulus(64'h33, 1'b0);
        applyStimulus(64'h34, 1'b0);
        idle();
        waitCycles(3);

        // K=1: every word is a full beat, back to back
        for (int i = 0; i < 5; i++) begin
            beat_t b;
            b.data = 256'h5000 + 256'(i);
            b.keep = 4'b0001;
            b.last = (i == 4);
            k1Q.push_back(b);
            k1Val  = 1'b1;
            k1Data = b.data;
            k1Last = b.last;
            @(negedge clk);
            checkOutput("k1_tready", 256'(k1InReady), 256'(1));
            @(posedge clk);
            #1;
            checkOutput("k1_tvalid", 256'(k1OutValid), 256'(1));
        end
        k1Val  = 1'b0;
        k1Last = 1'b0;
        waitCycles(3);

        // Every queued beat must have come out
        checkOutput("scoreboardA_empty", 256'(expQ.size()), 256'(0));
        checkOutput("scoreboardK1_empty", 256'(k1Q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
